alu_op_sequencer: RTL

- Single-requester sequencer for the 16-bit ALU register block (BR/MR result registers, 5-bit flag vector, C9/C10 bus write-back).
- Accepts one operation request via a valid/ready handshake and fires the ALU enable for exactly one cycle.
- Then sequences the BR write-back (C9) and, when required, the MR write-back (C10), gated by a bus grant.
- Returns the captured flags and a done pulse. Sits between the CPU control unit and the ALU.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_op_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: opcodes, FSM state encoding
// and flag bit positions.
package alu_seq_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned FLAG_W  = 5;

    localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB    = 3'b001;
    localparam logic [OP_W-1:0] OP_MPY    = 3'b010;
    localparam logic [OP_W-1:0] OP_AND    = 3'b011;
    localparam logic [OP_W-1:0] OP_OR     = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT    = 3'b101;
    localparam logic [OP_W-1:0] OP_SHIFTR = 3'b110;
    localparam logic [OP_W-1:0] OP_SHIFTL = 3'b111;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_EXEC  = 3'd1;
    localparam logic [STATE_W-1:0] S_WB_BR = 3'd2;
    localparam logic [STATE_W-1:0] S_WB_MR = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

    localparam int unsigned FLAG_ZF = 4;
    localparam int unsigned FLAG_CF = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_NF = 1;
    localparam int unsigned FLAG_MF = 0;

endpackage

// File: rtl/alu_op_sequencer.sv
// Single-requester sequencer: fires the ALU enable for one cycle, then walks the
// BR (C9) and optional MR (C10) write-backs under bus grant, and reports flags/done.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned     CNT_W  = 16,
    parameter logic [OP_W-1:0] MPY_OP = OP_MPY
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [OP_W-1:0]   i_req_op,
    input  logic              i_req_wb_mr,
    input  logic              i_bus_grant,
    input  logic [FLAG_W-1:0] i_alu_flags,
    output logic [OP_W-1:0]   o_ctrl_alu_op,
    output logic              o_ctrl_alu_en,
    output logic              o_c9,
    output logic              o_c10,
    output logic              o_busy,
    output logic              o_done,
    output logic [FLAG_W-1:0] o_flags,
    output logic [CNT_W-1:0]  o_op_count
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [OP_W-1:0]    op_q;
    logic               wbmr_q;
    logic               ready_q;
    logic [FLAG_W-1:0]  flags_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept_c;
    logic               flag_cap_c;

    assign accept_c    = ready_q & i_req_valid & (state == S_IDLE);
    assign o_req_ready = ready_q;
    assign o_flags     = flags_q;
    assign o_op_count  = cnt_q;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; only C9/C10 are gated by the live grant
    always_comb begin
        state_nxt     = state;
        o_ctrl_alu_op = '0;
        o_ctrl_alu_en = 1'b0;
        o_c9          = 1'b0;
        o_c10         = 1'b0;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        flag_cap_c    = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (accept_c) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                o_ctrl_alu_op = op_q;
                o_ctrl_alu_en = 1'b1;
                state_nxt     = S_WB_BR;
            end
            S_WB_BR: begin
                o_ctrl_alu_op = op_q;
                o_c9          = i_bus_grant;
                if (i_bus_grant) begin
                    flag_cap_c = 1'b1;
                    state_nxt  = wbmr_q ? S_WB_MR : S_DONE;
                end
            end
            S_WB_MR: begin
                o_ctrl_alu_op = op_q;
                o_c10         = i_bus_grant;
                if (i_bus_grant) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_ctrl_alu_op = op_q;
                o_done        = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                o_busy    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, ready, flag capture and completion counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q    <= '0;
            wbmr_q  <= 1'b0;
            ready_q <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            ready_q <= (state_nxt == S_IDLE);
            if (accept_c) begin
                op_q   <= i_req_op;
                wbmr_q <= i_req_wb_mr | (i_req_op == MPY_OP);
            end
            if (flag_cap_c) begin
                flags_q <= i_alu_flags;
            end
            if (state == S_DONE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
